lab4_event_streamer: RTL and testbench
======================================

// Module: lab4_event_streamer
// PURPOSE
//  Downstream of the LAB4 readout RAM: on a readout-complete pulse, WISHBONE-master-reads one event
//  from the l4_ram window and streams it as bytes to the TURFbus TD[7:0] output path.
//  Emits a 4-byte header, NWORDS data words (MSB byte first), then an optional checksum trailer.
//  Sole clock domain is wbc_clk; readout_complete is already synchronised into it upstream.
// PARAMETERS
//  NWORDS    16384  32-bit words per event (1..16384)
//  ADR_W     19     WISHBONE byte-address width to l4_ram
//  BASE_ADR  0      byte address of word 0; word k read at BASE_ADR + 4*k
//  SYNC      8'hA5  header sync byte
// PORTS
//  clk_i        in   1      wbc_clk
//  rst_n_i      in   1      asynchronous active-low reset
//  start_i      in   1      one-cycle pulse: event ready in RAM
//  buffer_i     in   5      LAB4 buffer address of that event, sampled with start_i
//  wbm_cyc_o    out  1      WB master cycle
//  wbm_stb_o    out  1      WB master strobe
//  wbm_we_o     out  1      always 0
//  wbm_adr_o    out  ADR_W  byte address
//  wbm_sel_o    out  4      always 4'hF
//  wbm_dat_i    in   32     read data
//  wbm_ack_i    in   1      ack
//  wbm_err_i    in   1      error
//  wbm_rty_i    in   1      retry
//  td_o         out  8      stream byte
//  td_valid_o   out  1      td_o valid
//  td_ready_i   in   1      sink accepts byte
//  busy_o       out  1      event in progress
//  done_o       out  1      one-cycle pulse after last byte accepted
//  drop_cnt_o   out  8      saturating count of start_i ignored while busy
// BEHAVIOUR
//  Reset (async, rst_n_i=0): all outputs 0; state IDLE; event counter 0; drop_cnt 0. Mid-event reset
//   drops cyc/stb immediately; partial packet abandoned, no done_o.
//  Byte handshake: byte transfers when td_valid_o & td_ready_i; td_o held stable while valid & !ready.
//  States: IDLE -> HDR(4 bytes) -> RD -> XFER(4 bytes) -> {RD | TRL | FIN} -> IDLE.
//   IDLE: start_i latches buffer_i, sets busy_o; td_valid_o=1 with SYNC on the next cycle.
//   HDR: bytes SYNC, evcnt[7:0], {buffer[4:0],3'b0}, 8'h00.
//   RD: cyc=stb=1, adr=BASE_ADR+4*k. ack: capture dat_i, drop cyc/stb same edge, -> XFER.
//    rty: drop stb for 1 cycle, reissue same address. err: capture 32'hDEADBEEF, set err flag, -> XFER.
//    Exactly one outstanding access; no bursts; cyc never held across XFER.
//   XFER: dat[31:24],[23:16],[15:8],[7:0]. k wraps only at NWORDS-1 -> TRL (or FIN if checksum off).
//   FIN: done_o=1 one cycle, busy_o=0, evcnt+1 (wraps 255->0), -> IDLE.
//  start_i while busy_o: ignored, drop_cnt_o +1, saturates at 255. start_i in FIN cycle also dropped.
//  Word counter width clog2(NWORDS)+1; address = BASE_ADR + {k,2'b00}, truncated to ADR_W.
//  Min event latency (ready=1, ack 1 cycle): 1 + 4 + NWORDS*(2+4) [+1] cycles.
// CONFIGURATION
//  LAB4_STREAM_CHECKSUM_EN defined: TRL state appends 1 byte = XOR of all header+data bytes, bit7
//   replaced by err flag (1 if any wbm_err_i in event). Undefined: no TRL, XFER last byte -> FIN;
//   err flag only reflected by DEADBEEF words.
// STRUCTURE
//  Shared package/include lab4_stream_pkg: SYNC default, DEADBEEF fill constant, state encoding
//   (IDLE/HDR/RD/XFER/TRL/FIN), header byte layout.
//  One sub-module: lab4_stream_serializer (32->4x8 byte holding register with valid/ready and
//   running XOR); top holds FSM, WB master, counters.
// TESTING
//  1 NWORDS=4, ready=1, RAM word k=32'h11223344+k, buffer_i=5'd3 -> bytes A5,00,18,00,11,22,33,44,
//    11,22,33,45,...; done_o once; adr 0,4,8,C.
//  2 td_ready_i random 50%, 2 events -> byte sequence identical to 1, evcnt byte 00 then 01, no dup/loss.
//  3 wbm_rty_i on word 1 twice, then ack -> adr 4 reissued 3 times, data unchanged, no err flag.
//  4 wbm_err_i on word 2 -> bytes DE,AD,BE,EF; with CHECKSUM_EN trailer bit7=1.
//  5 start_i 3x while busy -> drop_cnt_o=3; 300 drops -> 255; current packet unaffected.
//  6 rst_n_i low mid-XFER -> cyc/stb/td_valid 0 same cycle; after release new start_i gives header evcnt 00.

Source files
------------

// File: rtl/lab4_stream_pkg.sv
// ============================================================================
// Module   : lab4_stream_pkg
// Purpose  : Shared constants, state encoding and header layout for the
//            LAB4 event streamer. Optional macro: LAB4_STREAM_CHECKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package lab4_stream_pkg;

    localparam logic [7:0]  C_SYNC_DEFAULT = 8'hA5;
    localparam logic [31:0] C_DEADBEEF     = 32'hDEADBEEF;
    localparam logic [2:0]  C_LEN_WORD     = 3'd4;
    localparam logic [2:0]  C_LEN_TRL      = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_RD   = 3'd2,
        S_XFER = 3'd3,
        S_TRL  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    // Header is sent MSB byte first: SYNC, event count, buffer<<3, pad.
    function automatic logic [31:0] hdr_word(input logic [7:0] sync,
                                             input logic [7:0] evcnt,
                                             input logic [4:0] buf_adr);
        return {sync, evcnt, buf_adr, 3'b000, 8'h00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lab4_stream_serializer.sv
// ============================================================================
// Module   : lab4_stream_serializer
// Purpose  : 32-bit holding register shifted out as 1..4 bytes over a
//            valid/ready port; running XOR when LAB4_STREAM_CHECKSUM_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lab4_stream_serializer
    import lab4_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic [2:0]  i_len,
`ifdef LAB4_STREAM_CHECKSUM_EN
    input  logic        i_clr,
    output logic [7:0]  o_chk,
`endif
    output logic [7:0]  o_byte,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_last
);

    logic [31:0] r_word;
    logic [2:0]  r_cnt;
    logic        w_fire;

    assign o_valid = (r_cnt != 3'd0);
    assign o_byte  = r_word[31:24];
    assign w_fire  = o_valid & i_ready;
    assign o_last  = w_fire & (r_cnt == 3'd1);

    // A load always lands on an empty register or on the final byte's accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_cnt  <= i_len;
        end else if (w_fire) begin
            r_word <= {r_word[23:0], 8'h00};
            r_cnt  <= r_cnt - 3'd1;
        end
    end

`ifdef LAB4_STREAM_CHECKSUM_EN
    logic [7:0] r_xor;

    // Includes the byte being accepted this cycle so the trailer can load on it.
    assign o_chk = r_xor ^ (w_fire ? o_byte : 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xor <= '0;
        end else if (i_clr) begin
            r_xor <= '0;
        end else if (w_fire) begin
            r_xor <= r_xor ^ o_byte;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/lab4_event_streamer.sv
// ============================================================================
// Module   : lab4_event_streamer
// Purpose  : Reads one event from l4_ram over WISHBONE and streams it as
//            header + data bytes (+ checksum if LAB4_STREAM_CHECKSUM_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lab4_event_streamer
    import lab4_stream_pkg::*;
#(
    parameter int         NWORDS   = 16384,
    parameter int         ADR_W    = 19,
    parameter int         BASE_ADR = 0,
    parameter logic [7:0] SYNC     = C_SYNC_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [4:0]       buffer_i,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [3:0]       wbm_sel_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    input  logic             wbm_rty_i,
    output logic [7:0]       td_o,
    output logic             td_valid_o,
    input  logic             td_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [7:0]       drop_cnt_o
);

    localparam int               K_W    = $clog2(NWORDS) + 1;
    localparam logic [ADR_W-1:0] C_BASE = ADR_W'(BASE_ADR);
    localparam logic [K_W-1:0]   C_KEND = K_W'(NWORDS - 1);

    state_t         r_state, w_state_nxt;
    logic [K_W-1:0] r_k;
    logic [7:0]     r_evcnt;
    logic [7:0]     r_drop;
    logic           r_rty_hold;
    logic           w_stb;
    logic           w_load;
    logic [31:0]    w_ld_word;
    logic [2:0]     w_ld_len;
    logic           w_last;
    logic           w_k_end;
    logic           w_accept;

    assign w_k_end    = (r_k == C_KEND);
    assign w_accept   = (r_state == S_IDLE) & start_i;
    assign wbm_stb_o  = w_stb;
    assign wbm_we_o   = 1'b0;
    assign wbm_sel_o  = wbm_cyc_o ? 4'hF : 4'h0;
    assign wbm_adr_o  = wbm_cyc_o ? (C_BASE + ADR_W'({r_k, 2'b00})) : '0;
    assign drop_cnt_o = r_drop;

`ifdef LAB4_STREAM_CHECKSUM_EN
    logic       r_err;
    logic [7:0] w_chk;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_stb & wbm_err_i & ~wbm_ack_i) begin
            r_err <= 1'b1;
        end
    end
`endif

    lab4_stream_serializer u_ser (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .i_load  (w_load),
        .i_word  (w_ld_word),
        .i_len   (w_ld_len),
`ifdef LAB4_STREAM_CHECKSUM_EN
        .i_clr   (w_accept),
        .o_chk   (w_chk),
`endif
        .o_byte  (td_o),
        .o_valid (td_valid_o),
        .i_ready (td_ready_i),
        .o_last  (w_last)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ld_word   = '0;
        w_ld_len    = C_LEN_WORD;
        wbm_cyc_o   = 1'b0;
        w_stb       = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_load      = 1'b1;
                    w_ld_word   = hdr_word(SYNC, r_evcnt, buffer_i);
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                busy_o = 1'b1;
                if (w_last) w_state_nxt = S_RD;
            end
            S_RD: begin
                busy_o    = 1'b1;
                wbm_cyc_o = 1'b1;
                w_stb     = ~r_rty_hold;
                // ack wins over err; rty only matters when neither is present
                if (w_stb & (wbm_ack_i | wbm_err_i)) begin
                    w_load      = 1'b1;
                    w_ld_word   = wbm_ack_i ? wbm_dat_i : C_DEADBEEF;
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                busy_o = 1'b1;
                if (w_last) begin
                    if (w_k_end) begin
`ifdef LAB4_STREAM_CHECKSUM_EN
                        w_load      = 1'b1;
                        w_ld_word   = {r_err, w_chk[6:0], 24'h000000};
                        w_ld_len    = C_LEN_TRL;
                        w_state_nxt = S_TRL;
`else
                        w_state_nxt = S_FIN;
`endif
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_TRL: begin
                busy_o = 1'b1;
                if (w_last) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_k        <= '0;
            r_evcnt    <= '0;
            r_drop     <= '0;
            r_rty_hold <= 1'b0;
        end else begin
            if (w_accept) begin
                r_k <= '0;
            end else if ((r_state == S_XFER) & w_last & ~w_k_end) begin
                r_k <= r_k + K_W'(1);
            end
            r_rty_hold <= w_stb & wbm_rty_i & ~wbm_ack_i & ~wbm_err_i;
            if (r_state == S_FIN) begin
                r_evcnt <= r_evcnt + 8'd1;
            end
            if (start_i & (r_state != S_IDLE) & (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lab4_event_streamer.sv
// ============================================================================
// Module   : tb_lab4_event_streamer
// Purpose  : Scoreboard bench for lab4_event_streamer with a WISHBONE slave
//            model and random sink back-pressure.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lab4_event_streamer;

    localparam int NW    = 4;
    localparam int ADR_W = 19;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [4:0]       buffer = '0;
    logic             cyc, stb, we;
    logic [ADR_W-1:0] adr;
    logic [3:0]       sel;
    logic [31:0]      dat = '0;
    logic             ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [7:0]       td;
    logic             td_valid;
    logic             td_ready = 1'b1;
    logic             busy, done;
    logic [7:0]       drop_cnt;

    always #5 clk = ~clk;

    lab4_event_streamer #(
        .NWORDS(NW), .ADR_W(ADR_W), .BASE_ADR(0), .SYNC(8'hA5)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .buffer_i(buffer),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
        .wbm_sel_o(sel), .wbm_dat_i(dat), .wbm_ack_i(ack), .wbm_err_i(err),
        .wbm_rty_i(rty), .td_o(td), .td_valid_o(td_valid), .td_ready_i(td_ready),
        .busy_o(busy), .done_o(done), .drop_cnt_o(drop_cnt)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int          adr_q[$];
    logic [31:0] ram[NW];
    int          rty_n[NW];
    bit          err_w[NW];
    int          att[NW];
    int          ready_mode = 0;
    int          lat_max = 0;
    int          ev_model = 0;
    int          drop_model = 0;
    int          done_cnt = 0;
    int          done_exp = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sink: ready changes only just after the rising edge.
    always begin
        @(posedge clk); #1;
        case (ready_mode)
            0:       td_ready = 1'b1;
            1:       td_ready = 1'($urandom_range(0, 1));
            default: td_ready = 1'b0;
        endcase
    end

    // WISHBONE slave: scripted retry/error per word, random wait states.
    int wait_cnt = 0;
    int cur_lat = 0;
    always begin
        int k;
        @(posedge clk); #1;
        ack = 1'b0; err = 1'b0; rty = 1'b0; dat = $urandom;
        if (rst_n && cyc && stb) begin
            if (wait_cnt < cur_lat) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                cur_lat  = $urandom_range(0, lat_max);
                k = int'(adr[ADR_W-1:2]) % NW;
                if (adr_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL wb_adr: got %0h expected none", adr);
                end else begin
                    check("wb_adr", 64'(adr), 64'(adr_q.pop_front()));
                end
                if (att[k] < rty_n[k]) begin
                    rty = 1'b1; att[k]++;
                end else if (err_w[k]) begin
                    err = 1'b1;
                end else begin
                    ack = 1'b1; dat = ram[k];
                end
            end
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    logic [7:0] held;
    bit         held_v = 1'b0;
    always begin
        @(negedge clk);
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) check("td_hold", {td_valid, td}, {1'b1, held});
            held_v = 1'b0;
            if (td_valid && td_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL td_byte: got %0h expected none", td);
                end else begin
                    check("td_byte", 64'(td), 64'(exp_q.pop_front()));
                end
            end else if (td_valid) begin
                held = td; held_v = 1'b1;
            end
            if (done) begin
                done_cnt++;
                check("done_busy", 64'(busy), 64'd0);
            end
            if (cyc) check("wb_ctl", {sel, we, td_valid}, {4'hF, 1'b0, 1'b0});
        end
    end

    // Reference: expected byte stream and address sequence for one event.
    task automatic issue(input logic [4:0] b);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [31:0] w;
        bit          any_err;
        any_err = 1'b0;
        bytes = '{8'hA5, 8'(ev_model), {b, 3'b000}, 8'h00};
        for (int k = 0; k < NW; k++) begin
            att[k] = 0;
            w = err_w[k] ? 32'hDEADBEEF : ram[k];
            for (int i = 3; i >= 0; i--) bytes.push_back(w[8*i +: 8]);
            any_err |= err_w[k];
            for (int r = 0; r <= rty_n[k]; r++) adr_q.push_back(4 * k);
        end
`ifdef LAB4_STREAM_CHECKSUM_EN
        x = 8'h00;
        foreach (bytes[i]) x ^= bytes[i];
        bytes.push_back({any_err, x[6:0]});
`else
        x = 8'h00;
        if (any_err) x = 8'h00;
`endif
        foreach (bytes[i]) exp_q.push_back(bytes[i]);
        ev_model = (ev_model + 1) % 256;
        done_exp++;
        @(posedge clk); #1;
        buffer = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; buffer = 5'($urandom);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt < done_exp && t < 3000) begin
            @(negedge clk); t++;
        end
        if (t >= 3000) begin
            n_vec++; n_err++;
            $display("FAIL timeout: done_cnt %0d expected %0d", done_cnt, done_exp);
        end
        @(negedge clk);
        check("done_cnt", 64'(done_cnt), 64'(done_exp));
        check("byte_queue_left", 64'(exp_q.size()), 64'd0);
        check("adr_queue_left", 64'(adr_q.size()), 64'd0);
        check("drop_cnt", 64'(drop_cnt), 64'(drop_model));
        exp_q.delete(); adr_q.delete();
    endtask

    task automatic plain_ram();
        for (int k = 0; k < NW; k++) begin
            ram[k] = 32'h11223344 + k; rty_n[k] = 0; err_w[k] = 1'b0;
        end
    endtask

    task automatic drops(input int n, input bit back_to_back);
        for (int i = 0; i < n; i++) begin
            start = 1'b1;
            @(posedge clk); #1;
            if (!back_to_back) begin
                start = 1'b0;
                @(posedge clk); #1;
            end
            drop_model = (drop_model < 255) ? drop_model + 1 : 255;
        end
        start = 1'b0;
    endtask

    task automatic reset_mid(input bit in_rd);
        int t;
        t = 0;
        plain_ram();
        issue(5'($urandom));
        while (t < 2000 && !(in_rd ? cyc : (td_valid && exp_q.size() < 4 * NW))) begin
            @(negedge clk); t++;
        end
        if (t >= 2000) begin
            n_vec++; n_err++;
            $display("FAIL reset_wait: timeout in_rd=%0d", in_rd);
        end
        #2 rst_n = 1'b0;
        #1 check("reset_mid_out", {cyc, stb, td_valid, busy, done, drop_cnt}, 64'd0);
        exp_q.delete(); adr_q.delete();
        ev_model = 0; drop_model = 0; done_exp = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1 check("reset_out",
                 {cyc, stb, we, adr, sel, td, td_valid, busy, done, drop_cnt}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic event, full-rate sink, 1-cycle ack.
        plain_ram();
        issue(5'd3);
        wait_done();

        // Two events with random back-pressure and wait states.
        ready_mode = 1; lat_max = 2;
        issue(5'd3); wait_done();
        issue(5'd3); wait_done();

        // Retry twice on word 1.
        ready_mode = 0; lat_max = 0;
        plain_ram(); rty_n[1] = 2;
        issue(5'd7); wait_done();

        // Error on word 2.
        plain_ram(); err_w[2] = 1'b1;
        issue(5'd31); wait_done();

        // Drops while busy: 3, then saturation.
        plain_ram();
        ready_mode = 2;
        issue(5'd1);
        drops(3, 1'b0);
        ready_mode = 0;
        wait_done();
        ready_mode = 2;
        issue(5'd2);
        drops(300, 1'b1);
        ready_mode = 0;
        wait_done();

        // Randomised events.
        ready_mode = 1; lat_max = 2;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < NW; k++) begin
                ram[k]   = $urandom;
                rty_n[k] = $urandom_range(0, 2);
                err_w[k] = ($urandom_range(0, 3) == 0);
            end
            issue(5'($urandom));
            wait_done();
        end

        // Reset mid-XFER and mid-RD; the next event restarts evcnt at 00.
        ready_mode = 0; lat_max = 0;
        reset_mid(1'b0);
        plain_ram(); issue(5'd9); wait_done();
        lat_max = 3;
        reset_mid(1'b1);
        plain_ram(); issue(5'd4); wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
